// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, sends start/8 data/odd parity/stop
// on device-generated clock falls, checks the device ACK, and aborts on a response timeout.
//
// state   | meaning
// IDLE    | lines released, waiting for send
// INHIBIT | holding ps_clock low for INHIBIT_CYCLES
// START   | start bit driven, clock held low one more cycle
// BITS    | shifting data/parity/stop out on device clock falls
// ACK     | sampling device acknowledge on the next fall
// RELEASE | waiting for both lines to return high
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 3000,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER         = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       send,
    input  logic [7:0] din,
    input  logic       ps_clock_i,
    input  logic       ps_data_i,
    output logic       ps_clock_oe,
    output logic       ps_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int CW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        RELEASE
    } state_t;

    state_t        state, state_d;
    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic          clk_filt;
    logic [FW-1:0] fcnt;
    logic          fall;
    logic [CW-1:0] cnt, cnt_d;
    logic [TW-1:0] tmo, tmo_d;
    logic [9:0]    sh, sh_d;
    logic [3:0]    bitn, bitn_d;
    logic          data_oe, data_oe_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic          timeout_q, timeout_d;
    logic          timed_state;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Synchronizers and the filter idle at the released (high) line level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            fcnt     <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps_clock_i};
            dat_sync <= {dat_sync[0], ps_data_i};
            if (clk_s != clk_filt) begin
                if (fcnt == FLT_LAST) begin
                    clk_filt <= clk_s;
                    fcnt     <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign fall = clk_filt & ~clk_s & (fcnt == FLT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tmo       <= '0;
            sh        <= '0;
            bitn      <= '0;
            data_oe   <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            tmo       <= tmo_d;
            sh        <= sh_d;
            bitn      <= bitn_d;
            data_oe   <= data_oe_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign timed_state = (state == BITS) || (state == ACK) || (state == RELEASE);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        tmo_d     = tmo;
        sh_d      = sh;
        bitn_d    = bitn;
        data_oe_d = data_oe;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        timeout_d = timeout_q;

        case (state)
            IDLE: begin
                // The cycle that shows done is still closing the previous transfer.
                if (send && !done_q) begin
                    sh_d      = {1'b1, ~^din, din};
                    ack_err_d = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = START;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            START: begin
                tmo_d   = '0;
                bitn_d  = '0;
                state_d = BITS;
            end
            BITS: begin
                tmo_d = tmo + 1'b1;
                if (fall) begin
                    data_oe_d = ~sh[0];
                    sh_d      = {1'b0, sh[9:1]};
                    bitn_d    = bitn + 1'b1;
                    if (bitn == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                tmo_d = tmo + 1'b1;
                if (fall) begin
                    if (dat_s) begin
                        ack_err_d = 1'b1;
                    end
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                tmo_d = tmo + 1'b1;
                if (clk_filt && dat_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        // Timeout overrides whatever the line activity asked for this cycle.
        if (timed_state && (tmo == TMO_LAST)) begin
            state_d   = IDLE;
            tmo_d     = tmo;
            sh_d      = sh;
            bitn_d    = bitn;
            data_oe_d = 1'b0;
            ack_err_d = ack_err_q;
            timeout_d = 1'b1;
            done_d    = 1'b1;
        end
    end

    assign ps_clock_oe = (state == INHIBIT) || (state == START);
    assign ps_data_oe  = data_oe;
    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks frames out of the DUT while a scoreboard
// compares each completed transfer against a reference frame built from the byte value.
module tb_ps2_tx;

    localparam int INH  = 100;
    localparam int TMO  = 3000;
    localparam int FLT  = 4;
    localparam int HALF = 24;

    localparam int M_ACK    = 0;
    localparam int M_NACK   = 1;
    localparam int M_SILENT = 2;
    localparam int M_RESET  = 3;

    typedef struct {
        logic [9:0] frame;
        logic       ack_err;
        logic       timeout;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       send = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps_clock_i, ps_data_i;
    logic       ps_clock_oe, ps_data_oe, busy, done, ack_err, timeout;

    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned oe_fall_cyc = 0;
    logic        prev_coe = 1'b0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [9:0]  cap = '0;
    int          cap_n = 0;

    // Open-drain wired-AND of host and device on each line.
    assign ps_clock_i = ~(ps_clock_oe | dev_clk_low);
    assign ps_data_i  = ~(ps_data_oe | dev_dat_low);

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER        (FLT)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .send       (send),
        .din        (din),
        .ps_clock_i (ps_clock_i),
        .ps_data_i  (ps_data_i),
        .ps_clock_oe(ps_clock_oe),
        .ps_data_oe (ps_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout    (timeout)
    );

    always #20 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        prev_coe <= ps_clock_oe;
        if (prev_coe && !ps_clock_oe) oe_fall_cyc <= cyc;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Odd parity: total count of ones over data plus parity must be odd.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic push_exp(input logic [7:0] b, input int mode);
        exp_t e;
        if (mode == M_RESET) return;
        e.frame   = ref_frame(b);
        e.ack_err = (mode == M_NACK);
        e.timeout = (mode == M_SILENT);
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 with no transfer outstanding");
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_err", ack_err, mon_e.ack_err);
                    chk("timeout", timeout, mon_e.timeout);
                    chk("busy_at_done", busy, 1'b0);
                    chk("oe_at_done", {ps_clock_oe, ps_data_oe}, 2'b00);
                    if (mon_e.timeout) begin
                        chk("timeout_latency", cyc - oe_fall_cyc, TMO);
                    end else begin
                        chk("frame_bits", cap, mon_e.frame);
                        chk("frame_len", cap_n, 10);
                    end
                end
                @(negedge clock);
                chk("done_width", done, 1'b0);
            end
        end
    end

    task automatic dev_frame(input int mode, input bit glitch, input bit bsend);
        int n;
        n = 0;
        while (!ps_clock_oe && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!ps_clock_oe) begin
            n_chk++;
            n_fail++;
            $display("FAIL inhibit_start: ps_clock_oe=0 after 20 cycles, expected 1");
            return;
        end
        n = 0;
        while (ps_clock_oe && n < INH + 50) begin
            n++;
            @(negedge clock);
        end
        chk("inhibit_len", n, INH + 1);
        chk("start_bit", ps_data_oe, 1'b1);
        if (mode == M_SILENT) return;
        cap   = '0;
        cap_n = 0;
        repeat (HALF) @(negedge clock);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && mode != M_NACK) begin
                dev_dat_low = 1'b1;
                repeat (2) @(negedge clock);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            if (k <= 10) begin
                cap[k-1] = ps_data_i;
                cap_n++;
            end
            if (mode == M_RESET && k == 4) begin
                reset_n = 1'b0;
                #1;
                chk("reset_oe", {ps_clock_oe, ps_data_oe}, 2'b00);
                chk("reset_busy", busy, 1'b0);
                dev_clk_low = 1'b0;
                repeat (3) @(negedge clock);
                reset_n = 1'b1;
                repeat (4) @(negedge clock);
                return;
            end
            dev_clk_low = 1'b0;
            if (glitch && k == 5) begin
                repeat (8) @(negedge clock);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clock);
                dev_clk_low = 1'b0;
                repeat (HALF - 11) @(negedge clock);
            end else if (bsend && k == 3) begin
                repeat (5) @(negedge clock);
                din  = 8'h55;
                send = 1'b1;
                @(negedge clock);
                send = 1'b0;
                repeat (HALF - 6) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            if (k == 11) dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < TMO + 500) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_wait: busy=1 after %0d cycles, expected 0", n);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic do_send(input logic [7:0] b, input int mode, input bit glitch, input bit bsend);
        push_exp(b, mode);
        @(negedge clock);
        din  = b;
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
        din  = 8'($urandom);
        dev_frame(mode, glitch, bsend);
        wait_idle();
    endtask

    initial begin
        int n;
        logic [7:0] b;
        int mode;

        repeat (4) @(negedge clock);
        chk("rst_clock_oe", ps_clock_oe, 1'b0);
        chk("rst_data_oe", ps_data_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        do_send(8'hED, M_ACK, 1'b0, 1'b0);
        do_send(8'h01, M_ACK, 1'b0, 1'b0);
        do_send(8'h00, M_ACK, 1'b0, 1'b0);
        do_send(8'hFF, M_ACK, 1'b0, 1'b0);

        do_send(8'($urandom), M_NACK, 1'b0, 1'b0);
        chk("ack_err_sticky", ack_err, 1'b1);
        do_send(8'($urandom), M_ACK, 1'b0, 1'b0);

        do_send(8'($urandom), M_SILENT, 1'b0, 1'b0);
        chk("timeout_sticky", timeout, 1'b1);
        do_send(8'($urandom), M_ACK, 1'b0, 1'b0);

        do_send(8'h96, M_ACK, 1'b1, 1'b1);

        // send held across the done cycle: ignored there, accepted one cycle later
        push_exp(8'hC3, M_ACK);
        @(negedge clock);
        din  = 8'hC3;
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
        dev_frame(M_ACK, 1'b0, 1'b0);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_wait: done=0 after %0d cycles, expected 1", n);
        end
        din  = 8'hA5;
        send = 1'b1;
        @(negedge clock);
        chk("send_in_done_ignored", busy, 1'b0);
        push_exp(8'h3C, M_ACK);
        din = 8'h3C;
        @(negedge clock);
        send = 1'b0;
        chk("send_after_done_accepted", busy, 1'b1);
        dev_frame(M_ACK, 1'b0, 1'b0);
        wait_idle();

        do_send(8'h00, M_RESET, 1'b0, 1'b0);
        do_send(8'hF4, M_ACK, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            b    = 8'($urandom);
            mode = ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK;
            do_send(b, mode, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (10) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
